// File: rtl/stream_pkg.sv
// Shared constants and FSM state type for the stream framer and syncer.
// No ports: WINDOW_SZ, PATTERN_SZ, OUT_SZ, PATTERN, FILL, framer_state_t.
package stream_pkg;

    localparam int WINDOW_SZ  = 16;
    localparam int PATTERN_SZ = 8;
    localparam int OUT_SZ     = 8;

    localparam logic [PATTERN_SZ-1:0] PATTERN = 8'hE8;
    localparam logic [OUT_SZ-1:0]     FILL    = 8'h00;

    localparam int FILL_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } framer_state_t;

endpackage

// File: rtl/framer_hold_reg.sv
// One-entry valid/ready holding register with an explicit pop.
// Ports: clk, reset, in_valid/in_ready/in_data (push), pop, out_valid/out_data.
module framer_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic push;

    // Ready is withheld while reset is asserted so nothing is accepted then.
    assign in_ready = !out_valid && !reset;
    assign push     = in_valid && in_ready;

    // Push and pop never coincide: push needs the entry empty,
    // pop is only issued while it is full.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (pop) begin
                out_valid <= 1'b0;
            end
            if (push) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/stream_framer.sv
// Serialises payload bytes into windows of sync pattern + byte, MSB first.
// Ports: clk, reset, enable, data_in/_valid/_ready, stream, window_start,
// fill_cnt (only when FRAMER_STATS_EN is defined).
module stream_framer #(
    parameter int WINDOW_SZ  = stream_pkg::WINDOW_SZ,
    parameter int PATTERN_SZ = stream_pkg::PATTERN_SZ,
    parameter int OUT_SZ     = stream_pkg::OUT_SZ,
    parameter logic [PATTERN_SZ-1:0] PATTERN = stream_pkg::PATTERN,
    parameter logic [OUT_SZ-1:0]     FILL    = stream_pkg::FILL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [OUT_SZ-1:0] data_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic              stream,
    output logic              window_start
`ifdef FRAMER_STATS_EN
    ,
    output logic [15:0]       fill_cnt
`endif
);

    import stream_pkg::*;

    localparam int CW = $clog2(WINDOW_SZ);
    localparam logic [CW-1:0] HDR_LAST = CW'(PATTERN_SZ - 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_SZ - 1);

    if (WINDOW_SZ != PATTERN_SZ + OUT_SZ) begin : g_sz_chk
        $error("stream_framer: WINDOW_SZ != PATTERN_SZ + OUT_SZ");
    end

    framer_state_t     state, state_n;
    logic [CW-1:0]     cnt, cnt_n, cnt_inc;
    logic [OUT_SZ-1:0] shreg, shreg_n;
    logic              stream_n, ws_n;

    logic              hold_valid;
    logic [OUT_SZ-1:0] hold_data;
    logic              pop;
    logic [OUT_SZ-1:0] load_byte;
    logic [PATTERN_SZ-1:0] pat_sh;

    framer_hold_reg #(
        .W (OUT_SZ)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (data_in_valid),
        .in_ready  (data_in_ready),
        .in_data   (data_in),
        .pop       (pop),
        .out_valid (hold_valid),
        .out_data  (hold_data)
    );

    // cnt is the window index of the bit currently on stream.
    // Every output is computed one cycle ahead and registered.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        stream_n  = 1'b0;
        ws_n      = 1'b0;
        pop       = 1'b0;
        cnt_inc   = cnt + CW'(1);
        pat_sh    = PATTERN << cnt_inc;
        load_byte = hold_valid ? hold_data : FILL;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n  = HEADER;
                    cnt_n    = '0;
                    stream_n = PATTERN[PATTERN_SZ-1];
                    ws_n     = 1'b1;
                end
            end
            HEADER: begin
                cnt_n = cnt_inc;
                if (cnt == HDR_LAST) begin
                    // Load edge: payload MSB goes out now, rest shifts.
                    state_n  = PAYLOAD;
                    stream_n = load_byte[OUT_SZ-1];
                    shreg_n  = load_byte << 1;
                    pop      = hold_valid;
                end else begin
                    stream_n = pat_sh[PATTERN_SZ-1];
                end
            end
            PAYLOAD: begin
                if (cnt == WIN_LAST) begin
                    cnt_n = '0;
                    if (enable) begin
                        state_n  = HEADER;
                        stream_n = PATTERN[PATTERN_SZ-1];
                        ws_n     = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n    = cnt_inc;
                    stream_n = shreg[OUT_SZ-1];
                    shreg_n  = shreg << 1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            stream       <= 1'b0;
            window_start <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            shreg        <= shreg_n;
            stream       <= stream_n;
            window_start <= ws_n;
        end
    end

`ifdef FRAMER_STATS_EN
    logic fill_hit;

    assign fill_hit = (state == HEADER) && (cnt == HDR_LAST) && !hold_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt <= '0;
        end else if (fill_hit && (fill_cnt != 16'hFFFF)) begin
            fill_cnt <= fill_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_framer.sv
// Directed self-checking bench for stream_framer.
// Covers reset, data/fill windows, hold back-pressure, load-edge race, enable drop, mid-window reset.
module tb_stream_framer;

    import stream_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       stream;
    logic       window_start;
`ifdef FRAMER_STATS_EN
    logic [15:0] fill_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] txq[$];

    logic [15:0] bits, wsb, rdy;

    stream_framer dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .stream        (stream),
        .window_start  (window_start)
`ifdef FRAMER_STATS_EN
        ,
        .fill_cnt      (fill_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Put the next queued byte on the input if nothing is being offered.
    task automatic present();
        if (!data_in_valid && txq.size() != 0) begin
            data_in       = txq.pop_front();
            data_in_valid = 1'b1;
        end
    endtask

    // One clock; inputs are applied 1 time unit after the edge.
    task automatic tick();
        logic fire;
        fire = data_in_valid && data_in_ready;
        @(posedge clk);
        #1;
        if (fire) data_in_valid = 1'b0;
        present();
    endtask

    task automatic run_window(input int offer_at, input logic [7:0] offer_b,
                              input int drop_at, input int stop_at,
                              output logic [15:0] b, output logic [15:0] w,
                              output logic [15:0] r);
        b = '0;
        w = '0;
        r = '0;
        for (int i = 0; i <= stop_at; i++) begin
            tick();
            b[15-i] = stream;
            w[15-i] = window_start;
            r[15-i] = data_in_ready;
            if (i == offer_at) begin
                data_in       = offer_b;
                data_in_valid = 1'b1;
            end
            if (i == drop_at) enable = 1'b0;
        end
    endtask

    task automatic chk_win(input string tag, input logic [15:0] eb,
                           input logic [15:0] ew, input logic [15:0] er);
        chk({tag, "_bits"}, 32'(bits), 32'(eb));
        chk({tag, "_ws"},   32'(wsb),  32'(ew));
        chk({tag, "_rdy"},  32'(rdy),  32'(er));
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_stream", 32'(stream), 32'h0);
        chk("rst_ws",     32'(window_start), 32'h0);
        chk("rst_rdy",    32'(data_in_ready), 32'h0);
        chk("rst_state",  32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", 32'(data_in_ready), 32'h1);

        // A5 held before enable
        data_in       = 8'hA5;
        data_in_valid = 1'b1;
        tick();
        chk("a5_held_rdy", 32'(data_in_ready), 32'h0);
        enable = 1'b1;
        run_window(-1, 8'h00, -1, 15, bits, wsb, rdy);
        chk_win("win_a5", 16'hE8A5, 16'h8000, 16'h00FF);

        // Four fill windows back to back
        for (int k = 0; k < 4; k++) begin
            run_window(-1, 8'h00, -1, 15, bits, wsb, rdy);
            chk_win($sformatf("fill%0d", k), 16'hE800, 16'h8000, 16'hFFFF);
        end

        // 11 then 22 back to back: 22 waits for the load edge
        txq.push_back(8'h11);
        txq.push_back(8'h22);
        present();
        run_window(-1, 8'h00, -1, 15, bits, wsb, rdy);
        chk_win("win_11", 16'hE811, 16'h8000, 16'h0080);
        run_window(-1, 8'h00, -1, 15, bits, wsb, rdy);
        chk_win("win_22", 16'hE822, 16'h8000, 16'h00FF);
        chk("q_drained", 32'(txq.size()), 32'd0);
        chk("valid_low", 32'(data_in_valid), 32'h0);

        // Byte accepted exactly on the load edge: FILL now, byte next
        run_window(7, 8'h5A, -1, 15, bits, wsb, rdy);
        chk_win("race_fill", 16'hE800, 16'h8000, 16'hFF00);
        run_window(-1, 8'h00, -1, 15, bits, wsb, rdy);
        chk_win("race_5a", 16'hE85A, 16'h8000, 16'h00FF);

        // enable dropped at bit 3: window completes, then idle
        run_window(-1, 8'h00, 3, 15, bits, wsb, rdy);
        chk_win("drop_en", 16'hE800, 16'h8000, 16'hFFFF);
        tick();
        chk("idle_stream", 32'(stream), 32'h0);
        chk("idle_ws",     32'(window_start), 32'h0);
        chk("idle_state",  32'(dut.state), 32'(IDLE));
        tick();
        chk("idle_stream2", 32'(stream), 32'h0);

        // Reset at bit 10 with a second byte held
        txq.push_back(8'h77);
        txq.push_back(8'h33);
        present();
        tick();
        chk("77_held_rdy", 32'(data_in_ready), 32'h0);
        enable = 1'b1;
        run_window(-1, 8'h00, -1, 10, bits, wsb, rdy);
        chk_win("win_77_part", 16'hE860, 16'h8000, 16'h0080);
        reset = 1'b1;
        #1;
        chk("rst_mid_rdy", 32'(data_in_ready), 32'h0);
        tick();
        chk("rst_mid_stream", 32'(stream), 32'h0);
        chk("rst_mid_ws",     32'(window_start), 32'h0);
        chk("rst_mid_rdy2",   32'(data_in_ready), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rel_rdy", 32'(data_in_ready), 32'h1);
`ifdef FRAMER_STATS_EN
        chk("fill_cnt_rst", 32'(fill_cnt), 32'd0);
`endif

        // Held 33 must be gone: three fill windows, then C3
        run_window(-1, 8'h00, -1, 15, bits, wsb, rdy);
        chk_win("after_rst", 16'hE800, 16'h8000, 16'hFFFF);
        run_window(-1, 8'h00, -1, 15, bits, wsb, rdy);
        chk_win("fill_b", 16'hE800, 16'h8000, 16'hFFFF);
        run_window(10, 8'hC3, -1, 15, bits, wsb, rdy);
        chk_win("fill_c", 16'hE800, 16'h8000, 16'hFFE0);
        run_window(-1, 8'h00, 15, 15, bits, wsb, rdy);
        chk_win("win_c3", 16'hE8C3, 16'h8000, 16'h00FF);
`ifdef FRAMER_STATS_EN
        chk("fill_cnt_3", 32'(fill_cnt), 32'd3);
`endif
        tick();
        chk("end_stream", 32'(stream), 32'h0);
        chk("end_state",  32'(dut.state), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
